// File: rtl/gate_scheduler.sv
// Sequencer for the gate matrix-vector products of one recurrent-cell timestep.
// Each gate runs through CLEAR, ISSUE (NCOL column reads), DRAIN and RESULT, with a handshake on RESULT.
module gate_scheduler #(
    parameter int NCOL          = 16,
    parameter int NGATE         = 4,
    parameter int ADDR_BITWIDTH = $clog2(NCOL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     resultReady,
    output logic                     busy,
    output logic [ADDR_BITWIDTH-1:0] colAddress,
    output logic [1:0]               gateSel,
    output logic                     macClear,
    output logic                     macEn,
    output logic                     resultValid,
    output logic [1:0]               resultGate,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_BITWIDTH-1:0] COL_LAST  = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [1:0]               GATE_LAST = 2'(NGATE - 1);

    state_t                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] col_q, col_d;
    logic [1:0]               gate_q, gate_d;
    logic                     mac_en_q, mac_en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            gate_q   <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            gate_q   <= gate_d;
            mac_en_q <= mac_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        gate_d      = gate_q;
        // Memory data arrives one cycle after the address, so enable trails ISSUE by one cycle.
        mac_en_d    = (state_q == ISSUE);
        busy        = 1'b1;
        macClear    = 1'b0;
        resultValid = 1'b0;
        resultGate  = '0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                    gate_d  = '0;
                    col_d   = '0;
                end
            end
            CLEAR: begin
                macClear = 1'b1;
                col_d    = '0;
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + ADDR_BITWIDTH'(1);
                end
            end
            DRAIN: state_d = RESULT;
            RESULT: begin
                resultValid = 1'b1;
                resultGate  = gate_q;
                if (resultReady) begin
                    if (gate_q == GATE_LAST) begin
                        state_d = DONE;
                    end else begin
                        gate_d  = gate_q + 2'd1;
                        state_d = CLEAR;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_d  = IDLE;
                col_d    = '0;
                gate_d   = '0;
                mac_en_d = 1'b0;
            end
        endcase
    end

    assign colAddress = col_q;
    assign gateSel    = gate_q;
    assign macEn      = mac_en_q;

endmodule

// File: tb/tb_gate_scheduler.sv
// Self-checking bench for gate_scheduler: directed timing tables, corner sequences and a randomized model check.
module tb_gate_scheduler;

    localparam int NC = 16;
    localparam int NG = 4;

    logic       clk = 1'b0;
    logic       rst, start, rdy, start2;
    logic       busy, clr, en, rv, dn;
    logic [3:0] col;
    logic [1:0] gs, rg;
    logic       busy2, clr2, en2, rv2, dn2;
    logic [0:0] col2;
    logic [1:0] gs2, rg2;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    gate_scheduler #(.NCOL(NC), .NGATE(NG)) dut (
        .clk(clk), .reset(rst), .start(start), .resultReady(rdy),
        .busy(busy), .colAddress(col), .gateSel(gs), .macClear(clr), .macEn(en),
        .resultValid(rv), .resultGate(rg), .done(dn)
    );

    gate_scheduler #(.NCOL(2), .NGATE(1)) dut2 (
        .clk(clk), .reset(rst), .start(start2), .resultReady(1'b1),
        .busy(busy2), .colAddress(col2), .gateSel(gs2), .macClear(clr2), .macEn(en2),
        .resultValid(rv2), .resultGate(rg2), .done(dn2)
    );

    logic [12:0] obs;
    assign obs = {busy, clr, en, rv, dn, gs, rg, col};

    function automatic logic [12:0] mk(input logic b, input logic c, input logic e, input logic v,
                                       input logic d, input logic [1:0] g, input logic [1:0] r,
                                       input logic [3:0] a);
        return {b, c, e, v, d, g, r, a};
    endfunction

    typedef struct {
        int          cyc;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rdy = 1'b1; start2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: position k within a gate window (0 clear, 1..NC issue, NC+1 drain, NC+2 result).
    logic m_act, m_done, m_en;
    int   m_k, m_g;

    function automatic logic [12:0] model_out();
        logic       iss, res;
        logic [3:0] a;
        iss = m_act && m_k >= 1 && m_k <= NC;
        res = m_act && m_k == NC + 2;
        a   = iss ? 4'(m_k - 1) : 4'd0;
        return mk(m_act || m_done, m_act && m_k == 0, m_en, res, m_done, 2'(m_g),
                  res ? 2'(m_g) : 2'd0, a);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic y);
        logic new_en;
        new_en = m_act && m_k >= 1 && m_k <= NC;
        if (r) begin
            m_act = 0; m_done = 0; m_en = 0; m_k = 0; m_g = 0;
            return;
        end
        if (m_done) m_done = 0;
        else if (!m_act) begin
            if (s) begin m_act = 1; m_k = 0; m_g = 0; end
        end else if (m_k == NC + 2) begin
            if (y) begin
                if (m_g == NG - 1) begin m_act = 0; m_done = 1; end
                else begin m_g++; m_k = 0; end
            end
        end else m_k++;
        m_en = new_en;
    endtask

    initial begin
        int done_c, rv1cnt, gsbad, g3c, g2c, bad;
        logic [15:0] rvmask, dnmask;
        logic [8:0]  fexp;

        tbl[0]  = '{0,  mk(0,0,0,0,0,0,0,0)};
        tbl[1]  = '{1,  mk(1,1,0,0,0,0,0,0)};
        tbl[2]  = '{2,  mk(1,0,0,0,0,0,0,0)};
        tbl[3]  = '{3,  mk(1,0,1,0,0,0,0,1)};
        tbl[4]  = '{17, mk(1,0,1,0,0,0,0,15)};
        tbl[5]  = '{18, mk(1,0,1,0,0,0,0,0)};
        tbl[6]  = '{19, mk(1,0,0,1,0,0,0,0)};
        tbl[7]  = '{20, mk(1,1,0,0,0,1,0,0)};
        tbl[8]  = '{21, mk(1,0,0,0,0,1,0,0)};
        tbl[9]  = '{38, mk(1,0,0,1,0,1,1,0)};
        tbl[10] = '{39, mk(1,1,0,0,0,2,0,0)};
        tbl[11] = '{57, mk(1,0,0,1,0,2,2,0)};
        tbl[12] = '{76, mk(1,0,0,1,0,3,3,0)};
        tbl[13] = '{77, mk(1,0,0,0,1,3,0,0)};
        tbl[14] = '{78, mk(0,0,0,0,0,3,0,0)};
        tbl[15] = '{79, mk(1,1,0,0,0,0,0,0)};

        // Reset state of both instances
        do_reset();
        chk("reset_state", 0, 32'(obs), 32'(13'd0));
        chk("reset_state2", 0, 32'({busy2, clr2, en2, rv2, dn2, gs2, rg2, col2}), 32'd0);

        // Nominal run; extra starts at 5 (busy) and 77 (DONE) are ignored, start at 78 restarts
        for (int c = 0; c <= 79; c++) begin
            for (int i = 0; i < 16; i++)
                if (tbl[i].cyc == c) chk("nominal_tbl", c, 32'(obs), 32'(tbl[i].exp));
            if (c <= 78) begin
                fexp = {c >= 1 && c <= 77,
                        c >= 1 && c <= 58 && (c - 1) % 19 == 0,
                        c >= 3 && c <= 76 && (c - 3) % 19 < 16,
                        c >= 19 && c <= 76 && c % 19 == 0,
                        c == 77,
                        (c >= 2 && c <= 76 && (c - 2) % 19 < 16) ? 4'((c - 2) % 19) : 4'd0};
                chk("nominal_timing", c, 32'({busy, clr, en, rv, dn, col}), 32'(fexp));
            end
            start = (c == 0 || c == 4 || c == 5 || c == 19 || c == 77 || c == 78);
            tick();
        end
        start = 1'b0;

        // Backpressure: resultReady low for 5 cycles in gate-1 RESULT
        do_reset();
        done_c = -1; rv1cnt = 0; gsbad = 0; g3c = -1; g2c = -1;
        for (int c = 0; c <= 90; c++) begin
            if (rv && rg == 2'd1) begin
                rv1cnt++;
                if (gs != 2'd1) gsbad++;
            end
            if (rv && rg == 2'd2 && g2c < 0) g2c = c;
            if (rv && rg == 2'd3 && g3c < 0) g3c = c;
            if (dn && done_c < 0) done_c = c;
            start = (c == 0);
            rdy   = !(c >= 38 && c <= 42);
            tick();
        end
        rdy = 1'b1;
        chk("bp_hold_cycles", 0, rv1cnt, 6);
        chk("bp_gatesel_stable", 0, gsbad, 0);
        chk("bp_gate2_result", 0, g2c, 62);
        chk("bp_gate3_result", 0, g3c, 81);
        chk("bp_done_cycle", 0, done_c, 82);

        // Reset in the middle of gate-2 ISSUE (colAddress 7)
        do_reset();
        for (int c = 0; c < 47; c++) begin
            start = (c == 0);
            tick();
        end
        chk("midrst_pre", 47, 32'({busy, gs, col}), 32'({1'b1, 2'd2, 4'd7}));
        rst = 1'b1;
        tick();
        chk("midrst_zero", 48, 32'(obs), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (en || rv || dn || busy) bad++;
            tick();
        end
        chk("midrst_quiet", 0, bad, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrst_restart", 0, 32'({busy, clr, gs, col}), 32'({1'b1, 1'b1, 2'd0, 4'd0}));

        // Smallest configuration: NGATE=1, NCOL=2
        do_reset();
        rvmask = '0; dnmask = '0;
        for (int c = 0; c <= 10; c++) begin
            if (rv2) begin
                rvmask[c] = 1'b1;
                chk("small_rgate", c, 32'(rg2), 32'd0);
            end
            if (dn2) dnmask[c] = 1'b1;
            start2 = (c == 0);
            tick();
        end
        chk("small_rv_cycles", 0, 32'(rvmask), 32'h0020);
        chk("small_done_cycles", 0, 32'(dnmask), 32'h0040);

        // Randomized run against the reference model
        do_reset();
        m_act = 0; m_done = 0; m_en = 0; m_k = 0; m_g = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_start, r_rdy;
            chk("random", i, 32'(obs), 32'(model_out()));
            r_rst   = ($urandom_range(0, 299) == 0);
            r_start = ($urandom_range(0, 7) == 0);
            r_rdy   = ($urandom_range(0, 9) < 7);
            rst = r_rst; start = r_start; rdy = r_rdy;
            model_step(r_rst, r_start, r_rdy);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
